// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register port: decodes START/STOP, matches a 7-bit
// address, and services pointer writes, burst data writes and burst reads.
module i2c_target_regs #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         PTR_W    = 3
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Scl_i,
    input  logic             Sda_i,
    output logic             Sda_oe,
    output logic             Reg_wr,
    output logic [PTR_W-1:0] Reg_addr,
    output logic [7:0]       Reg_wdata,
    input  logic [7:0]       Rd_data,
    output logic             Busy,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR     = 4'd1,
        S_ADDR_ACK = 4'd2,
        S_RX_PTR   = 4'd3,
        S_PTR_ACK  = 4'd4,
        S_RX_DATA  = 4'd5,
        S_DATA_ACK = 4'd6,
        S_TX_BYTE  = 4'd7,
        S_RX_ACK   = 4'd8,
        S_WAIT     = 4'd9
    } state_t;

    state_t           state;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic [PTR_W-1:0] ptr;

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det, take_bit;

    // Synchronizers preset to the idle-high bus level so reset release makes no false START.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= Scl_i;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= Sda_i;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign take_bit  = scl_rise && (bit_cnt < 4'd8);

    assign Reg_addr  = ptr;
    assign dbg_state = state;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            ptr       <= '0;
            Sda_oe    <= 1'b0;
            Reg_wr    <= 1'b0;
            Reg_wdata <= '0;
            Busy      <= 1'b0;
        end else begin
            Reg_wr <= 1'b0;
            if (start_det) begin
                state   <= S_ADDR;
                bit_cnt <= '0;
                Sda_oe  <= 1'b0;
                Busy    <= 1'b0;
            end else if (stop_det) begin
                state  <= S_IDLE;
                Sda_oe <= 1'b0;
                Busy   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_WAIT: ;
                    S_ADDR: begin
                        if (take_bit) begin
                            shift_reg <= {shift_reg[6:0], sda_s2};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shift_reg[7:1] == SLV_ADDR) begin
                                state  <= S_ADDR_ACK;
                                Sda_oe <= 1'b1;
                                Busy   <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    // shift_reg[0] still holds the R/W bit of the address byte here.
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (shift_reg[0]) begin
                                state     <= S_TX_BYTE;
                                shift_reg <= Rd_data;
                                Sda_oe    <= ~Rd_data[7];
                            end else begin
                                state  <= S_RX_PTR;
                                Sda_oe <= 1'b0;
                            end
                        end
                    end
                    S_RX_PTR: begin
                        if (take_bit) begin
                            shift_reg <= {shift_reg[6:0], sda_s2};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            ptr    <= shift_reg[PTR_W-1:0];
                            Sda_oe <= 1'b1;
                            state  <= S_PTR_ACK;
                        end
                    end
                    S_PTR_ACK: begin
                        if (scl_fall) begin
                            Sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= S_RX_DATA;
                        end
                    end
                    S_RX_DATA: begin
                        if (take_bit) begin
                            shift_reg <= {shift_reg[6:0], sda_s2};
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                Reg_wr    <= 1'b1;
                                Reg_wdata <= {shift_reg[6:0], sda_s2};
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            Sda_oe <= 1'b1;
                            state  <= S_DATA_ACK;
                        end
                    end
                    S_DATA_ACK: begin
                        if (scl_fall) begin
                            Sda_oe  <= 1'b0;
                            ptr     <= ptr + PTR_W'(1);
                            bit_cnt <= '0;
                            state   <= S_RX_DATA;
                        end
                    end
                    // Bit 7 goes out on entry; each later falling edge advances one bit.
                    S_TX_BYTE: begin
                        if (take_bit) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            Sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= S_RX_ACK;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            shift_reg <= {shift_reg[6:0], 1'b0};
                            Sda_oe    <= ~shift_reg[6];
                        end
                    end
                    // Pointer advances at the ACK sample so Rd_data is settled by the falling edge.
                    S_RX_ACK: begin
                        if (scl_rise && bit_cnt == 4'd0) begin
                            bit_cnt <= 4'd1;
                            if (sda_s2) begin
                                Busy  <= 1'b0;
                                state <= S_WAIT;
                            end else begin
                                ptr <= ptr + PTR_W'(1);
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            bit_cnt   <= '0;
                            shift_reg <= Rd_data;
                            Sda_oe    <= ~Rd_data[7];
                            state     <= S_TX_BYTE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) that answers the bus transactions issued by the team's I2C controller functional model. It decodes START/STOP, matches a 7-bit device address, and services register-pointer writes, data writes and data reads against a user-side register port. SCL is input-only; this block never stretches the clock. The block sits on the bench or in the FPGA as the bus-side counterpart of the controller, on the 50 MHz system clock.

## Interface
- SLV_ADDR, 7'h50, 7-bit device address this target acknowledges
- PTR_W, 3, register pointer width; register space is 2**PTR_W bytes
- Clk  input  1  system clock, 50 MHz
- Rst_n  input  1  reset, synchronous, active-low
- Scl_i  input  1  raw SCL line, asynchronous to Clk
- Sda_i  input  1  raw SDA line, asynchronous to Clk
- Sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release
- Reg_wr  output  1  one-cycle write strobe
- Reg_addr  output  PTR_W  register pointer; write address on Reg_wr, read address otherwise
- Reg_wdata  output  8  write data, valid with Reg_wr
- Rd_data  input  8  read data for Reg_addr, combinational from user side
- Busy  output  1  1 from address match until STOP, repeated START or NACK

## Operation
- Reset value of every output: Sda_oe=0, Reg_wr=0, Reg_addr=0, Reg_wdata=0, Busy=0. Pointer and shift registers clear.
- Scl_i and Sda_i pass through 2-flop synchronizers. Edges are detected on the synchronized copies.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are honoured in every state, including mid-byte.
- START or repeated START goes to ADDR. STOP goes to IDLE. In both cases Sda_oe clears on the next cycle.
- Bits are sampled on the SCL rising edge, MSB first. Sda_oe changes only on the cycle after a detected SCL falling edge.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits. If addr[7:1] matches SLV_ADDR, go to ADDR_ACK. Otherwise go to IDLE with SDA released (NACK).
  - ADDR_ACK: drive ACK low for one SCL period and set Busy. If R/W=0, go to RX_PTR. If R/W=1, go to TX_BYTE.
  - RX_PTR: shift in 8 bits. Pointer = byte[PTR_W-1:0]; upper bits are ignored. Then PTR_ACK.
  - PTR_ACK: drive ACK, then go to RX_DATA.
  - RX_DATA: shift in 8 bits. One cycle after the 8th rising-edge sample, pulse Reg_wr with Reg_addr=pointer and Reg_wdata=byte. Then go to DATA_ACK.
  - DATA_ACK: drive ACK and increment the pointer (mod 2**PTR_W). Then go back to RX_DATA.
  - TX_BYTE: on the falling edge that ends the ACK, load Rd_data at Reg_addr=pointer and drive its bits (Sda_oe = ~bit). After 8 bits, release SDA and go to RX_ACK.
  - RX_ACK: sample the controller's bit. If ACK (0), increment the pointer and go to TX_BYTE. If NACK (1), clear Busy and go to WAIT, which releases SDA and waits for STOP or START.
- Pointer persists across transactions. A read without a preceding pointer write uses the last pointer value.

## Timing
- Input latency: 2 sync stages + 1 edge-detect stage, so an action occurs 3 Clk cycles after the raw SCL/SDA edge.
- Reg_wr is exactly 1 cycle wide, once per received data byte. It is never asserted for the address byte or the pointer byte.
- An ACK is asserted 1 cycle after the 8th-bit falling edge is detected, and released 1 cycle after the 9th-bit falling edge is detected.
- Supported bus speeds: 100 kHz and 400 kHz SCL. The minimum SCL high/low time is 30 Clk cycles.
- Reset mid-transfer: on the first Clk edge with Rst_n=0, Sda_oe=0 and the state becomes IDLE. After reset releases, the block ignores the bus until a fresh START.
- Rst_n wins over any simultaneous bus event.
- START and STOP detection take priority over a bit sample on the same cycle.

## Test plan
- Address mismatch: START, byte 0xA2 (address 0x51, write) -> SDA not driven in the 9th clock, Busy=0, no Reg_wr.
- Burst write: START, 0xA0, 0x02, 0xA5, 0x3C, STOP -> all bytes ACKed; Reg_wr pulses twice, with (2, 0xA5) then (3, 0x3C); Busy=0 after STOP.
- Read via repeated START: write pointer 0x06, Sr, 0xA1, controller ACKs one byte then NACKs -> reads bytes from regs 6 then 7; SDA released after the NACK.
- Pointer wrap: pointer 0x07, write 0x11, 0x22 -> Reg_wr at addresses 7 then 0.
- STOP mid-byte: STOP after 4 data bits -> no Reg_wr, state IDLE, Sda_oe=0.
- Reset mid-ACK: Rst_n low for 3 cycles while Sda_oe=1 -> Sda_oe=0 on the next edge; the next full write transaction succeeds.
